wrf_pkt_gen: RTL



---
 rtl/wrf_pkt_gen.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/wrf_pkt_gen.sv
// WR fabric frame transmitter: dst/src MAC, ethertype, then a PRBS payload,
// sent over a pipelined WB fabric source with frame and abort counters.
module wrf_pkt_gen #(
  parameter int g_max_len     = 1500,
  parameter int g_min_len     = 46,
  parameter int g_ack_timeout = 1023
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        start_i,
  input  logic [15:0] len_i,
  input  logic [47:0] dst_mac_i,
  input  logic [47:0] src_mac_i,
  input  logic [15:0] ethertype_i,
  input  logic [15:0] seed_i,
  output logic        src_cyc,
  output logic        src_stb,
  output logic        src_we,
  output logic [1:0]  src_sel,
  output logic [1:0]  src_adr,
  output logic [15:0] src_dat,
  input  logic        src_stall,
  input  logic        src_ack,
  input  logic        src_err,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] frame_cnt_o,
  output logic [31:0] err_cnt_o
);

  // state    | meaning
  // IDLE     | waiting for start_i, fabric released
  // HDR      | sending the 7 header words
  // PAY      | sending PRBS payload words
  // WAIT_ACK | all words strobed, collecting outstanding acks
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_HDR      = 2'd1;
  localparam logic [1:0] ST_PAY      = 2'd2;
  localparam logic [1:0] ST_WAIT_ACK = 2'd3;

  localparam int TW = (g_ack_timeout > 1) ? $clog2(g_ack_timeout + 1) : 1;
  localparam logic [TW-1:0] TMO_LOAD = TW'(g_ack_timeout - 1);

  logic [1:0]    r_state;
  logic          r_cyc;
  logic          r_stb;
  logic          r_done;
  logic [47:0]   r_dst;
  logic [47:0]   r_src;
  logic [15:0]   r_etype;
  logic [15:0]   r_lfsr;
  logic          r_odd;
  logic [2:0]    r_hidx;
  logic [10:0]   r_prem;
  logic [10:0]   r_out;
  logic [TW-1:0] r_tmo;
  logic [31:0]   r_frame_cnt;
  logic [31:0]   r_err_cnt;

  logic [15:0]   w_len;
  logic [10:0]   w_pwords;
  logic          w_acc;
  logic          w_ack;
  logic [10:0]   w_out_nxt;
  logic          w_fb;
  logic          w_last_pay;
  logic [15:0]   w_dat;
  logic [1:0]    w_sel;

  always_comb begin
    w_len = len_i;
    if (len_i < 16'(g_min_len))
      w_len = 16'(g_min_len);
    else if (len_i > 16'(g_max_len))
      w_len = 16'(g_max_len);
  end

  assign w_pwords   = 11'((w_len + 16'd1) >> 1);
  assign w_acc      = r_stb & ~src_stall;
  // acks with nothing outstanding are stray and must not underflow the count
  assign w_ack      = src_ack & (r_out != 11'd0);
  assign w_out_nxt  = r_out + {10'd0, w_acc} - {10'd0, w_ack};
  assign w_fb       = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  assign w_last_pay = (r_state == ST_PAY) && (r_prem == 11'd1);

  // data/sel are decoded from registers that only move on accept, so they
  // stay stable across stalls
  always_comb begin
    w_dat = 16'h0000;
    w_sel = 2'b11;
    case (r_state)
      ST_HDR: begin
        case (r_hidx)
          3'd0:    w_dat = r_dst[47:32];
          3'd1:    w_dat = r_dst[31:16];
          3'd2:    w_dat = r_dst[15:0];
          3'd3:    w_dat = r_src[47:32];
          3'd4:    w_dat = r_src[31:16];
          3'd5:    w_dat = r_src[15:0];
          3'd6:    w_dat = r_etype;
          default: w_dat = 16'h0000;
        endcase
      end
      ST_PAY: begin
        w_dat = r_lfsr;
        if (w_last_pay && r_odd) begin
          w_dat = {r_lfsr[15:8], 8'h00};
          w_sel = 2'b10;
        end
      end
      default: begin
        w_dat = 16'h0000;
        w_sel = 2'b11;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state     <= ST_IDLE;
      r_cyc       <= 1'b0;
      r_stb       <= 1'b0;
      r_done      <= 1'b0;
      r_dst       <= 48'd0;
      r_src       <= 48'd0;
      r_etype     <= 16'd0;
      r_lfsr      <= 16'd0;
      r_odd       <= 1'b0;
      r_hidx      <= 3'd0;
      r_prem      <= 11'd0;
      r_out       <= 11'd0;
      r_tmo       <= '0;
      r_frame_cnt <= 32'd0;
      r_err_cnt   <= 32'd0;
    end else begin
      r_done <= 1'b0;
      if ((r_state != ST_IDLE) && src_err) begin
        // a bus error wins even over a simultaneous final ack
        r_cyc     <= 1'b0;
        r_stb     <= 1'b0;
        r_done    <= 1'b1;
        r_out     <= 11'd0;
        r_err_cnt <= r_err_cnt + 32'd1;
        r_state   <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start_i) begin
              r_dst   <= dst_mac_i;
              r_src   <= src_mac_i;
              r_etype <= ethertype_i;
              r_lfsr  <= (seed_i == 16'd0) ? 16'hACE1 : seed_i;
              r_odd   <= w_len[0];
              r_prem  <= w_pwords;
              r_hidx  <= 3'd0;
              r_out   <= 11'd0;
              r_cyc   <= 1'b1;
              r_stb   <= 1'b1;
              r_state <= ST_HDR;
            end
          end
          ST_HDR: begin
            r_out <= w_out_nxt;
            if (w_acc) begin
              if (r_hidx == 3'd6)
                r_state <= ST_PAY;
              else
                r_hidx <= r_hidx + 3'd1;
            end
          end
          ST_PAY: begin
            r_out <= w_out_nxt;
            if (w_acc) begin
              r_lfsr <= {r_lfsr[14:0], w_fb};
              r_prem <= r_prem - 11'd1;
              if (r_prem == 11'd1) begin
                r_stb   <= 1'b0;
                r_tmo   <= TMO_LOAD;
                r_state <= ST_WAIT_ACK;
              end
            end
          end
          ST_WAIT_ACK: begin
            r_out <= w_out_nxt;
            if (w_out_nxt == 11'd0) begin
              r_cyc       <= 1'b0;
              r_done      <= 1'b1;
              r_frame_cnt <= r_frame_cnt + 32'd1;
              r_state     <= ST_IDLE;
            end else if (w_ack) begin
              r_tmo <= TMO_LOAD;
            end else if (r_tmo == '0) begin
              r_cyc     <= 1'b0;
              r_done    <= 1'b1;
              r_out     <= 11'd0;
              r_err_cnt <= r_err_cnt + 32'd1;
              r_state   <= ST_IDLE;
            end else begin
              r_tmo <= r_tmo - 1'b1;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign src_cyc     = r_cyc;
  assign src_stb     = r_stb;
  assign src_we      = 1'b1;
  assign src_adr     = 2'b00;
  assign src_sel     = w_sel;
  assign src_dat     = w_dat;
  assign busy_o      = r_cyc;
  assign done_o      = r_done;
  assign frame_cnt_o = r_frame_cnt;
  assign err_cnt_o   = r_err_cnt;

endmodule
